// File: rtl/id_stage_param.sv
// Decode stage: register file with write-through bypass, ARM-subset decoder,
// condition check and the ID/EX pipeline register with flush/stall bubbles.
module id_stage_param #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int PC_W   = 32,
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [31:0]       instruction,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [3:0]        status_reg,
   input  logic              hazard,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [3:0]        wb_dest,
   input  logic [DATA_W-1:0] wb_result,
   input  logic [3:0]        dbg_sel,
   output logic              id_ready,
   output logic [3:0]        src1,
   output logic [3:0]        src2,
   output logic              two_src,
   output logic              ex_valid,
   output logic              ex_wb_en,
   output logic              ex_mem_r_en,
   output logic              ex_mem_w_en,
   output logic              ex_b,
   output logic              ex_s,
   output logic [3:0]        ex_exe_cmd,
   output logic [DATA_W-1:0] ex_val_rn,
   output logic [DATA_W-1:0] ex_val_rm,
   output logic              ex_imm,
   output logic [11:0]       ex_shift_op,
   output logic [23:0]       ex_simm24,
   output logic [3:0]        ex_dest,
   output logic [PC_W-1:0]   ex_pc,
   output logic [DATA_W-1:0] dbg_data,
   output logic [PERF_W-1:0] bubble_cnt
);

   logic [DATA_W-1:0] r_rf [NREG];

   logic [1:0]        w_mode;
   logic              w_load, w_store, w_cond;
   logic              w_wb, w_mr, w_mw, w_b, w_s, w_live;
   logic [3:0]        w_cmd;
   logic [DATA_W-1:0] w_val_rn, w_val_rm;

   logic              r_valid, r_wb, r_mr, r_mw, r_b, r_s, r_imm;
   logic [3:0]        r_cmd, r_dest;
   logic [DATA_W-1:0] r_val_rn, r_val_rm;
   logic [11:0]       r_shift;
   logic [23:0]       r_simm;
   logic [PC_W-1:0]   r_pc;
   logic [PERF_W-1:0] r_bub;

   // Indices at or above NREG are unimplemented: they read 0 even while being written.
   function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int k = 0; k < NREG; k++)
         if (idx == 4'(k))
            v = (wb_en && wb_dest == idx) ? wb_result : r_rf[k];
      return v;
   endfunction

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] sr);
      logic n, z, cy, v, p;
      {n, z, cy, v} = sr;
      case (c)
         4'b0000: p = z;
         4'b0001: p = ~z;
         4'b0010: p = cy;
         4'b0011: p = ~cy;
         4'b0100: p = n;
         4'b0101: p = ~n;
         4'b0110: p = v;
         4'b0111: p = ~v;
         4'b1000: p = cy & ~z;
         4'b1001: p = ~cy | z;
         4'b1010: p = (n == v);
         4'b1011: p = (n != v);
         4'b1100: p = ~z & (n == v);
         4'b1101: p = z | (n != v);
         4'b1110: p = 1'b1;
         default: p = 1'b0;
      endcase
      return p;
   endfunction

   assign w_mode   = instruction[27:26];
   assign w_load   = (w_mode == 2'b01) &  instruction[20];
   assign w_store  = (w_mode == 2'b01) & ~instruction[20];
   assign w_cond   = cond_pass(instruction[31:28], status_reg);
   assign w_live   = id_valid & w_cond;

   assign id_ready = ~hazard | flush;
   assign src1     = instruction[19:16];
   assign src2     = w_store ? instruction[15:12] : instruction[3:0];
   assign two_src  = ~instruction[25] | w_load;

   assign w_val_rn = rf_read(src1);
   assign w_val_rm = rf_read(src2);
   assign dbg_data = rf_read(dbg_sel);

   always_comb begin
      w_cmd = 4'b0000;
      w_wb  = 1'b0;
      w_mr  = 1'b0;
      w_mw  = 1'b0;
      w_b   = 1'b0;
      w_s   = 1'b0;
      case (w_mode)
         2'b00: begin
            w_s  = instruction[20];
            w_wb = 1'b1;
            case (instruction[24:21])
               4'b1101: w_cmd = 4'b0001;
               4'b1111: w_cmd = 4'b1001;
               4'b0100: w_cmd = 4'b0010;
               4'b0101: w_cmd = 4'b0011;
               4'b0010: w_cmd = 4'b0100;
               4'b0110: w_cmd = 4'b0101;
               4'b0000: w_cmd = 4'b0110;
               4'b1100: w_cmd = 4'b0111;
               4'b0001: w_cmd = 4'b1000;
               4'b1010: begin w_cmd = 4'b0100; w_wb = 1'b0; end
               4'b1000: begin w_cmd = 4'b0110; w_wb = 1'b0; end
               default: begin w_s = 1'b0; w_wb = 1'b0; end
            endcase
         end
         2'b01: begin
            w_cmd = 4'b0010;
            w_wb  = w_load;
            w_mr  = w_load;
            w_mw  = w_store;
         end
         2'b10:   w_b = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) r_rf[k] <= '0;
      end else begin
         for (int k = 0; k < NREG; k++)
            if (wb_en && wb_dest == 4'(k)) r_rf[k] <= wb_result;
      end
   end

   // ID/EX boundary: flush and stall both insert an all-zero bubble; only a stall is counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush || hazard) begin
         {r_valid, r_wb, r_mr, r_mw, r_b, r_s, r_imm} <= '0;
         r_cmd    <= '0;
         r_dest   <= '0;
         r_val_rn <= '0;
         r_val_rm <= '0;
         r_shift  <= '0;
         r_simm   <= '0;
         r_pc     <= '0;
      end else begin
         r_valid  <= w_live;
         r_wb     <= w_wb & w_live;
         r_mr     <= w_mr & w_live;
         r_mw     <= w_mw & w_live;
         r_b      <= w_b  & w_live;
         r_s      <= w_s  & w_live;
         r_cmd    <= w_live ? w_cmd : 4'b0000;
         r_imm    <= instruction[25];
         r_dest   <= instruction[15:12];
         r_val_rn <= w_val_rn;
         r_val_rm <= w_val_rm;
         r_shift  <= instruction[11:0];
         r_simm   <= instruction[23:0];
         r_pc     <= pc_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_bub <= '0;
      else if (hazard && !flush && r_bub != '1)
         r_bub <= r_bub + PERF_W'(1);
   end

   assign ex_valid    = r_valid;
   assign ex_wb_en    = r_wb;
   assign ex_mem_r_en = r_mr;
   assign ex_mem_w_en = r_mw;
   assign ex_b        = r_b;
   assign ex_s        = r_s;
   assign ex_exe_cmd  = r_cmd;
   assign ex_val_rn   = r_val_rn;
   assign ex_val_rm   = r_val_rm;
   assign ex_imm      = r_imm;
   assign ex_shift_op = r_shift;
   assign ex_simm24   = r_simm;
   assign ex_dest     = r_dest;
   assign ex_pc       = r_pc;
   assign bubble_cnt  = r_bub;

endmodule

// File: tb/tb_id_stage_param.sv
// Bench for id_stage_param (NREG=8, PERF_W=4): directed literal checks plus a
// randomized run compared every cycle against a table-driven behavioural model.
module tb_id_stage_param;
   localparam int DATA_W = 32;
   localparam int NREG   = 8;
   localparam int PC_W   = 32;
   localparam int PERF_W = 4;

   logic clk, rst, id_valid, hazard, flush, wb_en;
   logic [31:0] instruction;
   logic [PC_W-1:0] pc_in;
   logic [3:0] status_reg, wb_dest, dbg_sel;
   logic [DATA_W-1:0] wb_result;
   logic id_ready, two_src, ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
   logic [3:0] src1, src2, ex_exe_cmd, ex_dest;
   logic [DATA_W-1:0] ex_val_rn, ex_val_rm, dbg_data;
   logic [11:0] ex_shift_op;
   logic [23:0] ex_simm24;
   logic [PC_W-1:0] ex_pc;
   logic [PERF_W-1:0] bubble_cnt;

   id_stage_param #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .PERF_W(PERF_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .instruction(instruction), .pc_in(pc_in),
      .status_reg(status_reg), .hazard(hazard), .flush(flush), .wb_en(wb_en),
      .wb_dest(wb_dest), .wb_result(wb_result), .dbg_sel(dbg_sel), .id_ready(id_ready),
      .src1(src1), .src2(src2), .two_src(two_src), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
      .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s),
      .ex_exe_cmd(ex_exe_cmd), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_imm(ex_imm),
      .ex_shift_op(ex_shift_op), .ex_simm24(ex_simm24), .ex_dest(ex_dest), .ex_pc(ex_pc),
      .dbg_data(dbg_data), .bubble_cnt(bubble_cnt));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic v, wb, mr, mw, b, s, imm;
      logic [3:0] cmd, dest;
      logic [31:0] rn, rm;
      logic [11:0] sh;
      logic [23:0] simm;
      logic [31:0] pc;
   } ex_t;

   logic [3:0] opc_tab [11] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8};
   logic [3:0] cmd_tab [11] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h4, 4'h6};
   logic [31:0] mrf [16];
   ex_t exp_ex;
   int  exp_bub;

   function automatic logic m_cond(input logic [3:0] c, input logic [3:0] sr);
      logic n, z, cy, v;
      {n, z, cy, v} = sr;
      case (c)
         0: return z;          1: return !z;
         2: return cy;         3: return !cy;
         4: return n;          5: return !n;
         6: return v;          7: return !v;
         8: return cy && !z;   9: return !cy || z;
         10: return n == v;    11: return n != v;
         12: return !z && n == v;
         13: return z || n != v;
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] idx);
      if (int'(idx) >= NREG) return 32'h0;
      if (wb_en && wb_dest == idx) return wb_result;
      return mrf[idx];
   endfunction

   function automatic logic m_store(input logic [31:0] ins);
      return ins[27:26] == 2'b01 && !ins[20];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_ex  = '0;
         exp_bub = 0;
         for (int i = 0; i < 16; i++) mrf[i] = 32'h0;
      end else begin
         if (flush || hazard) begin
            exp_ex = '0;
            if (hazard && !flush && exp_bub < (1 << PERF_W) - 1) exp_bub++;
         end else begin
            ex_t e;
            e = '0;
            e.v = id_valid && m_cond(instruction[31:28], status_reg);
            if (e.v) begin
               if (instruction[27:26] == 2'b00) begin
                  for (int i = 0; i < 11; i++)
                     if (instruction[24:21] == opc_tab[i]) begin
                        e.cmd = cmd_tab[i];
                        e.wb  = (i < 9);
                        e.s   = instruction[20];
                     end
               end else if (instruction[27:26] == 2'b01) begin
                  e.cmd = 4'h2;
                  e.wb  = instruction[20];
                  e.mr  = instruction[20];
                  e.mw  = !instruction[20];
               end else if (instruction[27:26] == 2'b10) begin
                  e.b = 1'b1;
               end
            end
            e.rn   = m_read(instruction[19:16]);
            e.rm   = m_read(m_store(instruction) ? instruction[15:12] : instruction[3:0]);
            e.imm  = instruction[25];
            e.sh   = instruction[11:0];
            e.simm = instruction[23:0];
            e.dest = instruction[15:12];
            e.pc   = pc_in;
            exp_ex = e;
         end
         if (wb_en && int'(wb_dest) < NREG) mrf[wb_dest] = wb_result;
      end
   end

   // Compare process: runs shortly after every rising edge, inputs are stable then.
   always @(posedge clk) begin
      #2;
      chk("ex_valid", ex_valid, exp_ex.v);
      chk("ex_wb_en", ex_wb_en, exp_ex.wb);
      chk("ex_mem_r_en", ex_mem_r_en, exp_ex.mr);
      chk("ex_mem_w_en", ex_mem_w_en, exp_ex.mw);
      chk("ex_b", ex_b, exp_ex.b);
      chk("ex_s", ex_s, exp_ex.s);
      if (exp_ex.v) chk("ex_exe_cmd", ex_exe_cmd, exp_ex.cmd);
      chk("ex_val_rn", ex_val_rn, exp_ex.rn);
      chk("ex_val_rm", ex_val_rm, exp_ex.rm);
      chk("ex_imm", ex_imm, exp_ex.imm);
      chk("ex_shift_op", ex_shift_op, exp_ex.sh);
      chk("ex_simm24", ex_simm24, exp_ex.simm);
      chk("ex_dest", ex_dest, exp_ex.dest);
      chk("ex_pc", ex_pc, exp_ex.pc);
      chk("bubble_cnt", bubble_cnt, exp_bub);
      chk("id_ready", id_ready, !hazard || flush);
      chk("src1", src1, instruction[19:16]);
      chk("src2", src2, m_store(instruction) ? instruction[15:12] : instruction[3:0]);
      chk("two_src", two_src, !instruction[25] || (instruction[27:26] == 2'b01 && instruction[20]));
      chk("dbg_data", dbg_data, m_read(dbg_sel));
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      int k;
      ins = $urandom;
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
      if (k <= 4) begin
         ins[27:26] = 2'b00;
         ins[24:21] = opc_tab[$urandom_range(0, 10)];
      end else if (k == 5) ins[27:26] = 2'b00;
      else if (k == 6) ins[27:26] = 2'b01;
      else if (k == 7) ins[27:26] = 2'b10;
      else if (k == 8) ins[27:26] = 2'b11;
      return ins;
   endfunction

   initial begin
      rst = 1'b1; id_valid = 1'b0; instruction = '0; pc_in = '0; status_reg = '0;
      hazard = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_dest = '0; wb_result = '0; dbg_sel = '0;
      repeat (2) @(negedge clk);
      chk("rst ex_valid", ex_valid, 0);
      chk("rst bubble_cnt", bubble_cnt, 0);
      chk("rst ex_pc", ex_pc, 0);
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i);
         #1 chk("rst dbg_data", dbg_data, 0);
      end
      @(negedge clk);
      rst = 1'b0;

      wb_en = 1'b1; wb_dest = 4'd2; wb_result = 32'h77;
      @(negedge clk);
      instruction = 32'hE0831003; id_valid = 1'b1; pc_in = 32'h100;
      wb_dest = 4'd3; wb_result = 32'hA5;
      @(negedge clk);
      chk("add rn bypass", ex_val_rn, 32'hA5);
      chk("add rm bypass", ex_val_rm, 32'hA5);
      chk("add cmd", ex_exe_cmd, 4'b0010);
      chk("add wb_en", ex_wb_en, 1);
      chk("add pc", ex_pc, 32'h100);

      wb_en = 1'b0; instruction = 32'hE5842000;
      #1 chk("str src2", src2, 4'd2);
      chk("str src1", src1, 4'd4);
      @(negedge clk);
      chk("str rm", ex_val_rm, 32'h77);
      chk("str mem_w", ex_mem_w_en, 1);
      chk("str wb_en", ex_wb_en, 0);

      instruction = 32'h00831003; status_reg = 4'b0000;
      @(negedge clk);
      chk("addeq fail valid", ex_valid, 0);
      chk("addeq fail rn loaded", ex_val_rn, 32'hA5);
      status_reg = 4'b0100;
      @(negedge clk);
      chk("addeq pass valid", ex_valid, 1);

      hazard = 1'b1;
      #1 chk("hazard id_ready", id_ready, 0);
      repeat (3) @(negedge clk);
      chk("hazard bubbles", bubble_cnt, 3);
      chk("hazard valid", ex_valid, 0);
      flush = 1'b1;
      #1 chk("flush+hazard id_ready", id_ready, 1);
      @(negedge clk);
      chk("flush+hazard count", bubble_cnt, 3);
      chk("flush+hazard valid", ex_valid, 0);
      flush = 1'b0; hazard = 1'b0;

      wb_en = 1'b1; wb_dest = 4'd12; wb_result = 32'h5;
      @(negedge clk);
      wb_en = 1'b0; dbg_sel = 4'd12;
      #1 chk("R12 dropped", dbg_data, 0);
      wb_en = 1'b1; wb_dest = 4'd7;
      @(negedge clk);
      wb_en = 1'b0; dbg_sel = 4'd7;
      #1 chk("R7 written", dbg_data, 32'h5);

      hazard = 1'b1;
      repeat (20) @(negedge clk);
      chk("bubble saturate", bubble_cnt, 15);
      hazard = 1'b0;

      instruction = 32'hE0831003; status_reg = 4'b0000;
      @(negedge clk);
      chk("pre-rst valid", ex_valid, 1);
      rst = 1'b1;
      #1 chk("async rst valid", ex_valid, 0);
      chk("async rst count", bubble_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         id_valid    = ($urandom_range(0, 7) != 0);
         instruction = rand_instr();
         pc_in       = $urandom;
         status_reg  = 4'($urandom);
         hazard      = ($urandom_range(0, 4) == 0);
         flush       = ($urandom_range(0, 7) == 0);
         wb_en       = ($urandom_range(0, 1) == 0);
         wb_dest     = 4'($urandom);
         wb_result   = $urandom;
         dbg_sel     = 4'($urandom);
         rst         = (c % 500 == 250);
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
